id_exe_stage: RTL and testbench
===============================

# id_exe_stage

Decode-to-execute boundary of the pipelined CPU. It sits directly downstream of the decode control unit and consumes its control word (wreg, m2reg, wmem, aluc, aluimm, regrt) and forwarding selects (fwda, fwdb). It muxes forwarded operands, sign-extends the immediate, selects the destination register, and detects load-use hazards, inserting a one-cycle bubble. It registers everything into the ID/EXE pipeline register and feeds edestReg/em2reg/ewreg back to the control unit.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- wreg, m2reg, wmem, aluimm, regrt  in  1 each  decode control word
- aluc  in  4  ALU op (0010 add, 0110 sub, 0001 or, 0000 and, 1100 xor)
- fwda, fwdb  in  2 each  forward selects from control unit
- rs, rt, rd  in  5 each  instruction register fields
- imm  in  16  instruction [15:0]
- qa, qb  in  DATA_W  register-file read data
- ealu  in  DATA_W  ALU result currently in EXE
- malu  in  DATA_W  ALU result in MEM
- mdo  in  DATA_W  data-memory read data in MEM
- mm2reg  in  1  MEM-stage load flag
- stall  out  1  combinational; freezes PC and IF/ID
- ewreg, em2reg, ewmem, ealuimm  out  1 each  registered control
- ealuc  out  4  registered ALU op
- edestReg  out  5  registered destination
- eqa, eqb  out  DATA_W  registered forwarded operands
- eimm  out  DATA_W  registered sign-extended immediate
- stall_count  out  STALL_CNT_W  saturating count of bubbles inserted

## Operation
- Operand A mux: fwda 00 → qa; 01 → ealu; 10 → (mm2reg ? mdo : malu); 11 reserved → qa. Same for B with fwdb/qb.
- Register 0 override: rs == 0 forces A = qa; rt == 0 forces B = qb, regardless of fwd.
- dest = regrt ? rt : rd. imm sign-extended: {{16{imm[15]}}, imm}.
- Load-use hazard: stall = em2reg & ewreg & (edestReg != 0) & ((rs == edestReg) | (~regrt & rt == edestReg) | (wmem & rt == edestReg)). Uses this block's own registered outputs.
- On stall: pipeline register loads bubble (all control 0, edestReg 0, operands/imm 0); stall_count increments and saturates at all-ones.
- No stall: pipeline register loads the control word, dest, muxed operands and imm.
- Bubble carries ewreg=0, so the re-presented instruction never stalls twice on the same load. The load is then in MEM; fwd 10 with mm2reg=1 selects mdo.

## Timing
- Reset (sync, clk edge with reset=1): all registered outputs 0, stall_count 0. stall then evaluates to 0.
- Latency: inputs at edge N appear on e* outputs after edge N+1 (1 cycle).
- stall is combinational from registered state plus rs/rt/regrt/wmem; valid the same cycle, no registered delay.
- Stall duration exactly 1 cycle per load-use pair; back-to-back loads with dependence each stall once.
- Reset asserted during a stall cycle: reset wins; bubble and counter increment discarded; outputs 0 next cycle.
- stall_count at max: stays at max on further stalls, no wrap.

## Structure
- Shared CPU package holds: aluc encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR), fwd select encodings (FWD_REG, FWD_EXE, FWD_MEM), REG_ZERO constant.
- One sub-module: operand_fwd_mux (2-bit select, reg/ealu/malu/mdo/mm2reg/zero-override), instantiated twice for A and B.
- Hazard logic and pipeline register stay in the top module.

## Test plan
- Reset: hold reset 2 cycles with nonzero inputs → all e* outputs 0, stall 0, stall_count 0.
- ADD pass-through: fwda=fwdb=00, qa=5, qb=7, aluc=0010, rd=3, regrt=0 → next cycle eqa=5, eqb=7, ealuc=0010, edestReg=3, ewreg=1.
- EXE/MEM forwarding: rs=4, fwda=01, ealu=0x11; rt=5, fwdb=10, mm2reg=0, malu=0x22 → eqa=0x11, eqb=0x22. Repeat with mm2reg=1, mdo=0x33 → eqb=0x33. Set rs=0 with fwda=01 → eqa=qa.
- Load-use: LW rt=8 (regrt=1, m2reg=1, imm=0xFFFC → eimm=0xFFFFFFFC), then ADD rs=8 → stall=1 for one cycle, next e* is bubble (ewreg=0, edestReg=0), stall_count=1. Re-presented ADD with fwda=10, mm2reg=1, mdo=0x99 → stall=0, eqa=0x99.
- Saturation: STALL_CNT_W=2, force 5 load-use pairs → stall_count ends at 3.
- Reset mid-stall: assert reset in a stall cycle → next cycle outputs 0, stall_count 0, stall 0.

Source files
------------

// File: rtl/id_exe_stage_pkg.sv
// rtl/id_exe_stage_pkg.sv - shared CPU encodings for the decode/execute boundary
package id_exe_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1100;

    // 2'b11 is reserved and behaves as FWD_REG
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_exe_stage_operand_fwd_mux.sv
// rtl/id_exe_stage_operand_fwd_mux.sv - forwarded operand select with register-0 override
module operand_fwd_mux
    import id_exe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel_i,
    input  logic [4:0]        reg_idx_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic [DATA_W-1:0] ealu_i,
    input  logic [DATA_W-1:0] malu_i,
    input  logic [DATA_W-1:0] mdo_i,
    input  logic              mm2reg_i,
    output logic [DATA_W-1:0] operand_o
);

    // r0 is hardwired, so nothing forwarded to it may be observed
    always_comb begin
        operand_o = reg_val_i;
        if (reg_idx_i != REG_ZERO) begin
            case (sel_i)
                FWD_EXE: operand_o = ealu_i;
                FWD_MEM: operand_o = mm2reg_i ? mdo_i : malu_i;
                default: operand_o = reg_val_i;
            endcase
        end
    end

endmodule

// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - ID/EXE pipeline register with operand forwarding and load-use stall
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wreg,
    input  logic                   m2reg,
    input  logic                   wmem,
    input  logic                   aluimm,
    input  logic                   regrt,
    input  logic [3:0]             aluc,
    input  logic [1:0]             fwda,
    input  logic [1:0]             fwdb,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic [4:0]             rd,
    input  logic [15:0]            imm,
    input  logic [DATA_W-1:0]      qa,
    input  logic [DATA_W-1:0]      qb,
    input  logic [DATA_W-1:0]      ealu,
    input  logic [DATA_W-1:0]      malu,
    input  logic [DATA_W-1:0]      mdo,
    input  logic                   mm2reg,
    output logic                   stall,
    output logic                   ewreg,
    output logic                   em2reg,
    output logic                   ewmem,
    output logic                   ealuimm,
    output logic [3:0]             ealuc,
    output logic [4:0]             edestReg,
    output logic [DATA_W-1:0]      eqa,
    output logic [DATA_W-1:0]      eqb,
    output logic [DATA_W-1:0]      eimm,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   ewreg_q, ewreg_d;
    logic                   em2reg_q, em2reg_d;
    logic                   ewmem_q, ewmem_d;
    logic                   ealuimm_q, ealuimm_d;
    logic [3:0]             ealuc_q, ealuc_d;
    logic [4:0]             edest_q, edest_d;
    logic [DATA_W-1:0]      eqa_q, eqa_d;
    logic [DATA_W-1:0]      eqb_q, eqb_d;
    logic [DATA_W-1:0]      eimm_q, eimm_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] opa, opb;
    logic [4:0]        dest;
    logic              rt_read;

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .sel_i     (fwda),
        .reg_idx_i (rs),
        .reg_val_i (qa),
        .ealu_i    (ealu),
        .malu_i    (malu),
        .mdo_i     (mdo),
        .mm2reg_i  (mm2reg),
        .operand_o (opa)
    );

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .sel_i     (fwdb),
        .reg_idx_i (rt),
        .reg_val_i (qb),
        .ealu_i    (ealu),
        .malu_i    (malu),
        .mdo_i     (mdo),
        .mm2reg_i  (mm2reg),
        .operand_o (opb)
    );

    assign dest = regrt ? rt : rd;

    // rt is a source for R-type ops and for stores (store data)
    assign rt_read = ~regrt | wmem;

    // A bubble clears ewreg_q, so a re-presented instruction cannot stall twice
    assign stall = em2reg_q & ewreg_q & (edest_q != REG_ZERO) &
                   ((rs == edest_q) | (rt_read & (rt == edest_q)));

    always_comb begin
        ewreg_d     = 1'b0;
        em2reg_d    = 1'b0;
        ewmem_d     = 1'b0;
        ealuimm_d   = 1'b0;
        ealuc_d     = 4'd0;
        edest_d     = REG_ZERO;
        eqa_d       = '0;
        eqb_d       = '0;
        eimm_d      = '0;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            ewreg_d   = wreg;
            em2reg_d  = m2reg;
            ewmem_d   = wmem;
            ealuimm_d = aluimm;
            ealuc_d   = aluc;
            edest_d   = dest;
            eqa_d     = opa;
            eqb_d     = opb;
            eimm_d    = {{(DATA_W-16){imm[15]}}, imm};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ewreg_q     <= 1'b0;
            em2reg_q    <= 1'b0;
            ewmem_q     <= 1'b0;
            ealuimm_q   <= 1'b0;
            ealuc_q     <= 4'd0;
            edest_q     <= REG_ZERO;
            eqa_q       <= '0;
            eqb_q       <= '0;
            eimm_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            ewreg_q     <= ewreg_d;
            em2reg_q    <= em2reg_d;
            ewmem_q     <= ewmem_d;
            ealuimm_q   <= ealuimm_d;
            ealuc_q     <= ealuc_d;
            edest_q     <= edest_d;
            eqa_q       <= eqa_d;
            eqb_q       <= eqb_d;
            eimm_q      <= eimm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ewreg       = ewreg_q;
    assign em2reg      = em2reg_q;
    assign ewmem       = ewmem_q;
    assign ealuimm     = ealuimm_q;
    assign ealuc       = ealuc_q;
    assign edestReg    = edest_q;
    assign eqa         = eqa_q;
    assign eqb         = eqb_q;
    assign eimm        = eimm_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// tb/tb_id_exe_stage.sv - directed self-checking bench for id_exe_stage
module tb_id_exe_stage;

    localparam int DATA_W      = 32;
    localparam int STALL_CNT_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wreg, m2reg, wmem, aluimm, regrt;
    logic [3:0]        aluc;
    logic [1:0]        fwda, fwdb;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] qa, qb, ealu, malu, mdo;
    logic              mm2reg;
    logic              stall;
    logic              ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]        ealuc;
    logic [4:0]        edestReg;
    logic [DATA_W-1:0] eqa, eqb, eimm;
    logic [STALL_CNT_W-1:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_exe_stage #(.DATA_W(DATA_W), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .regrt(regrt),
        .aluc(aluc), .fwda(fwda), .fwdb(fwdb),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .qa(qa), .qb(qb), .ealu(ealu), .malu(malu), .mdo(mdo), .mm2reg(mm2reg),
        .stall(stall),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
        .ealuc(ealuc), .edestReg(edestReg),
        .eqa(eqa), .eqb(eqb), .eimm(eimm), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        wreg = 1'b1; m2reg = 1'b0; wmem = 1'b0; aluimm = 1'b0; regrt = 1'b0;
        aluc = 4'b0010; fwda = 2'b00; fwdb = 2'b00;
        rs = s; rt = t; rd = d; imm = 16'h0;
    endtask

    task automatic present_load(input logic [4:0] t);
        set_alu(5'd2, t, 5'd0);
        m2reg = 1'b1; regrt = 1'b1; aluimm = 1'b1; imm = 16'hFFFC;
        step();
    endtask

    // Load into r8 followed by a dependent-or-not instruction; re-present after a bubble
    task automatic load_pair(input string tag, input logic [4:0] s, input logic [4:0] t,
                             input logic rgt, input logic wm, input logic exp_stall);
        present_load(5'd8);
        set_alu(s, t, 5'd10);
        regrt = rgt; wmem = wm; wreg = ~wm;
        #1;
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        step();
        if (exp_stall) begin
            check({tag, "_bubble_wreg"}, {31'd0, ewreg}, 32'd0);
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_alu(5'd7, 5'd9, 5'd6);
        m2reg = 1'b1; wmem = 1'b1; aluimm = 1'b1; imm = 16'h8001;
        qa = 32'hDEAD; qb = 32'hBEEF; ealu = 32'h1; malu = 32'h2; mdo = 32'h3; mm2reg = 1'b1;
        step();
        step();
        check("rst_ewreg", {31'd0, ewreg}, 32'd0);
        check("rst_em2reg", {31'd0, em2reg}, 32'd0);
        check("rst_ewmem", {31'd0, ewmem}, 32'd0);
        check("rst_dest", {27'd0, edestReg}, 32'd0);
        check("rst_eqa", eqa, 32'd0);
        check("rst_eimm", eimm, 32'd0);
        check("rst_cnt", {30'd0, stall_count}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        set_alu(5'd1, 5'd2, 5'd3);
        qa = 32'd5; qb = 32'd7; mm2reg = 1'b0;
        step();
        check("add_eqa", eqa, 32'd5);
        check("add_eqb", eqb, 32'd7);
        check("add_aluc", {28'd0, ealuc}, 32'h2);
        check("add_dest", {27'd0, edestReg}, 32'd3);
        check("add_ewreg", {31'd0, ewreg}, 32'd1);

        set_alu(5'd4, 5'd5, 5'd3);
        qa = 32'hA; qb = 32'hB; fwda = 2'b01; ealu = 32'h11;
        fwdb = 2'b10; mm2reg = 1'b0; malu = 32'h22; mdo = 32'h33;
        step();
        check("fwd_exe_a", eqa, 32'h11);
        check("fwd_malu_b", eqb, 32'h22);
        mm2reg = 1'b1;
        step();
        check("fwd_mdo_b", eqb, 32'h33);
        rs = 5'd0; rt = 5'd0;
        step();
        check("r0_a", eqa, 32'hA);
        check("r0_b", eqb, 32'hB);
        rs = 5'd4; fwda = 2'b11;
        step();
        check("fwd_rsv_a", eqa, 32'hA);

        present_load(5'd8);
        check("lw_eimm", eimm, 32'hFFFFFFFC);
        check("lw_dest", {27'd0, edestReg}, 32'd8);
        check("lw_em2reg", {31'd0, em2reg}, 32'd1);
        check("lw_aluimm", {31'd0, ealuimm}, 32'd1);
        set_alu(5'd8, 5'd9, 5'd10);
        fwda = 2'b01; ealu = 32'h55; mm2reg = 1'b0;
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        step();
        check("lu_bub_wreg", {31'd0, ewreg}, 32'd0);
        check("lu_bub_dest", {27'd0, edestReg}, 32'd0);
        check("lu_bub_eqa", eqa, 32'd0);
        check("lu_cnt", {30'd0, stall_count}, 32'd1);
        check("lu_stall_once", {31'd0, stall}, 32'd0);
        fwda = 2'b10; mm2reg = 1'b1; mdo = 32'h99;
        step();
        check("lu_eqa_mdo", eqa, 32'h99);
        check("lu_dest", {27'd0, edestReg}, 32'd10);

        load_pair("rt_rtype", 5'd1, 5'd8, 1'b0, 1'b0, 1'b1);
        check("cnt2", {30'd0, stall_count}, 32'd2);
        load_pair("rt_immop", 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        load_pair("rt_store", 5'd1, 5'd8, 1'b1, 1'b1, 1'b1);
        check("cnt3", {30'd0, stall_count}, 32'd3);
        load_pair("rs_dep4", 5'd8, 5'd1, 1'b0, 1'b0, 1'b1);
        load_pair("rs_dep5", 5'd8, 5'd1, 1'b0, 1'b0, 1'b1);
        check("cnt_sat", {30'd0, stall_count}, 32'd3);

        present_load(5'd0);
        set_alu(5'd0, 5'd0, 5'd10);
        #1;
        check("r0_load_nostall", {31'd0, stall}, 32'd0);
        step();

        present_load(5'd8);
        set_alu(5'd8, 5'd1, 5'd10);
        #1;
        check("mid_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_ewreg", {31'd0, ewreg}, 32'd0);
        check("mid_rst_em2reg", {31'd0, em2reg}, 32'd0);
        check("mid_rst_dest", {27'd0, edestReg}, 32'd0);
        check("mid_rst_cnt", {30'd0, stall_count}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
